// File: rtl/i2c_bus_arbiter_if.sv
// Requester and i2c-master side signals of the i2c bus arbiter.
// slave = arbiter view, master = requesters plus i2c master view.
interface i2c_bus_arbiter_if;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_rw;
  logic [3:0]  req_two_bytes;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [15:0] rsp_data;
  logic        rsp_ack;
  logic        rsp_timeout;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [15:0] m_data;
  logic        m_rw;
  logic        m_two_bytes;
  logic        m_ready;
  logic [15:0] m_read_data;
  logic        m_ack;

  modport slave (
    input  req, req_addr, req_data, req_rw, req_two_bytes,
    input  m_ready, m_read_data, m_ack,
    output grant, done, rsp_data, rsp_ack, rsp_timeout,
    output m_start, m_addr, m_data, m_rw, m_two_bytes
  );

  modport master (
    output req, req_addr, req_data, req_rw, req_two_bytes,
    output m_ready, m_read_data, m_ack,
    input  grant, done, rsp_data, rsp_ack, rsp_timeout,
    input  m_start, m_addr, m_data, m_rw, m_two_bytes
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c master between four requesters.
// Optional watchdog abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input logic clk,
  input logic rst,
  i2c_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
  } state_t;

  state_t      state;
  logic [1:0]  last;
  logic [1:0]  cur;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic [3:0]  grant_q;
  logic [3:0]  done_q;
  logic [15:0] rsp_data_q;
  logic        rsp_ack_q;
  logic        m_start_q;
  logic [6:0]  m_addr_q;
  logic [15:0] m_data_q;
  logic        m_rw_q;
  logic        m_two_q;

  // first pending requester after the last winner
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [19:0] cnt;
  logic        rsp_to_q;
  logic        to_hit;

  assign to_hit = (state == WAIT_BUSY ||
                   (state == WAIT_DONE && !bus.m_ready)) &&
                  cnt == TIMEOUT_CYCLES - 20'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 2'd3;
      cur        <= 2'd0;
      grant_q    <= '0;
      done_q     <= '0;
      rsp_data_q <= '0;
      rsp_ack_q  <= 1'b0;
      m_start_q  <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_rw_q     <= 1'b0;
      m_two_q    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt        <= '0;
      rsp_to_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (bus.m_ready && found) begin
            cur       <= win;
            grant_q   <= 4'b1 << win;
            m_start_q <= 1'b1;
            m_addr_q  <= bus.req_addr[int'(win)*7 +: 7];
            m_data_q  <= bus.req_data[int'(win)*16 +: 16];
            m_rw_q    <= bus.req_rw[win];
            m_two_q   <= bus.req_two_bytes[win];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          m_start_q <= 1'b0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.m_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.m_ready) begin
            rsp_data_q <= bus.m_read_data;
            rsp_ack_q  <= bus.m_ack;
            done_q     <= grant_q;
            grant_q    <= '0;
            last       <= cur;
            state      <= IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_to_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      if (state == IDLE) begin
        cnt <= '0;
      end else if (to_hit) begin
        rsp_ack_q <= 1'b0;
        rsp_to_q  <= 1'b1;
        done_q    <= grant_q;
        grant_q   <= '0;
        last      <= cur;
        state     <= IDLE;
      end else if (state != ISSUE) begin
        cnt <= cnt + 20'd1;
      end
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_ack     = rsp_ack_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_rw        = m_rw_q;
  assign bus.m_two_bytes = m_two_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_to_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: directed requests, queued
// expected grants/completions, a monitor and an i2c master model.
module tb_i2c_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if bus();

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(20'd100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  grant;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        rw;
    logic        two;
  } gexp_t;

  typedef struct packed {
    logic [3:0]  done;
    logic [15:0] data;
    logic        ack;
    logic        to;
  } dexp_t;

  gexp_t exp_g[$];
  dexp_t exp_d[$];
  gexp_t ge;
  dexp_t de;

  int checks = 0;
  int errors = 0;
  int mdl_busy = 3;
  logic [15:0] mdl_data = 16'h1234;
  logic mdl_ack = 1'b1;
  logic mdl_hang = 1'b0;
  int rem[4];
  logic prev_start = 1'b0;

  logic [6:0]  addr_t [4];
  logic [15:0] data_t [4];
  logic [3:0]  rw_t;
  logic [3:0]  two_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[7*i +: 7]  = addr_t[i];
      bus.req_data[16*i +: 16] = data_t[i];
    end
    bus.req_rw        = rw_t;
    bus.req_two_bytes = two_t;
  endtask

  task automatic push_g(int i);
    gexp_t e;
    e.grant = 4'b1 << i;
    e.addr  = addr_t[i];
    e.data  = data_t[i];
    e.rw    = rw_t[i];
    e.two   = two_t[i];
    exp_g.push_back(e);
  endtask

  task automatic push_d(int i, logic [15:0] d, logic a, logic t);
    dexp_t e;
    e.done = 4'b1 << i;
    e.data = d;
    e.ack  = a;
    e.to   = t;
    exp_d.push_back(e);
  endtask

  task automatic wait_drain(string name, int maxc);
    int n;
    n = 0;
    while ((exp_g.size() != 0 || exp_d.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_g.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending grants %0d dones %0d, expected 0",
               name, exp_g.size(), exp_d.size());
      exp_g.delete();
      exp_d.delete();
    end
  endtask

  task automatic wait_grant(int i, int maxc);
    for (int n = 0; n < maxc && !bus.grant[i]; n++) @(negedge clk);
  endtask

  // monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.m_start) begin
        chk("m_start_width", {31'd0, prev_start}, 32'd0);
        if (exp_g.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %b, expected none", bus.grant);
        end else begin
          ge = exp_g.pop_front();
          chk("grant", {28'd0, bus.grant}, {28'd0, ge.grant});
          chk("m_addr", {25'd0, bus.m_addr}, {25'd0, ge.addr});
          chk("m_data", {16'd0, bus.m_data}, {16'd0, ge.data});
          chk("m_rw", {31'd0, bus.m_rw}, {31'd0, ge.rw});
          chk("m_two_bytes", {31'd0, bus.m_two_bytes}, {31'd0, ge.two});
        end
      end
      if (bus.done != 4'd0) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got %b, expected none", bus.done);
        end else begin
          de = exp_d.pop_front();
          chk("done", {28'd0, bus.done}, {28'd0, de.done});
          chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, de.data});
          chk("rsp_ack", {31'd0, bus.rsp_ack}, {31'd0, de.ack});
          chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, de.to});
          chk("grant_at_done", {28'd0, bus.grant}, 32'd0);
        end
      end
    end
    prev_start = rst ? 1'b0 : bus.m_start;
  end

  // requesters drop req after their last expected done
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.done[i]) begin
          if (rem[i] > 0) rem[i]--;
          if (rem[i] == 0) bus.req[i] = 1'b0;
        end
      end
    end
  end

  // i2c master model
  initial begin
    bus.m_ready     = 1'b1;
    bus.m_read_data = 16'h0;
    bus.m_ack       = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_start) begin
        bus.m_ready = 1'b0;
        for (int i = 0; i < mdl_busy && !rst; i++) @(negedge clk);
        while (mdl_hang && !rst) @(negedge clk);
        bus.m_read_data = mdl_data;
        bus.m_ack       = mdl_ack;
        bus.m_ready     = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req = 4'd0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    addr_t[0] = 7'h50; addr_t[1] = 7'h51;
    addr_t[2] = 7'h52; addr_t[3] = 7'h53;
    data_t[0] = 16'hA000; data_t[1] = 16'hA111;
    data_t[2] = 16'hA222; data_t[3] = 16'hA333;
    rw_t  = 4'b0101;
    two_t = 4'b0011;
    apply_fields();
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    chk("rst_done", {28'd0, bus.done}, 32'd0);
    chk("rst_m_start", {31'd0, bus.m_start}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_m_addr", {25'd0, bus.m_addr}, 32'd0);
    rst = 1'b0;

    // all four held: 0,1,2,3,0
    mdl_busy = 3; mdl_data = 16'h1234; mdl_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_g(k % 4);
      push_d(k % 4, 16'h1234, 1'b1, 1'b0);
    end
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    bus.req = 4'b1111;
    wait_drain("all_four", 400);
    repeat (5) @(negedge clk);
    chk("idle_after_all4", {28'd0, bus.grant}, 32'd0);

    // single request, held off while master not ready
    bus.m_ready = 1'b0;
    addr_t[0] = 7'h48; data_t[0] = 16'h00C3;
    rw_t[0] = 1'b1; two_t[0] = 1'b1;
    apply_fields();
    mdl_busy = 50; mdl_data = 16'h1A80; mdl_ack = 1'b1;
    rem[0] = 1;
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("no_grant_ready_low", {28'd0, bus.grant}, 32'd0);
    push_g(0);
    push_d(0, 16'h1A80, 1'b1, 1'b0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("start_latency", {31'd0, bus.m_start}, 32'd1);
    chk("m_addr_48", {25'd0, bus.m_addr}, 32'h48);
    wait_drain("single", 200);

    // NACK from the master
    mdl_busy = 6; mdl_data = 16'h5555; mdl_ack = 1'b0;
    push_g(1);
    push_d(1, 16'h5555, 1'b0, 1'b0);
    rem[1] = 1;
    bus.req = 4'b0010;
    wait_drain("nack", 100);

    // req[2] drops mid-transaction; last=1 so order 2,3,1
    mdl_busy = 20; mdl_data = 16'hC0DE; mdl_ack = 1'b1;
    push_g(2); push_g(3); push_g(1);
    push_d(2, 16'hC0DE, 1'b1, 1'b0);
    push_d(3, 16'hC0DE, 1'b1, 1'b0);
    push_d(1, 16'hC0DE, 1'b1, 1'b0);
    rem[1] = 1; rem[2] = 1; rem[3] = 1;
    bus.req = 4'b1110;
    wait_grant(2, 20);
    repeat (4) @(negedge clk);
    bus.req[2] = 1'b0;
    wait_drain("req_drop", 400);

    // reset in WAIT_DONE
    mdl_busy = 40; mdl_data = 16'h7777;
    push_g(0);
    rem[0] = 1;
    bus.req = 4'b0001;
    wait_grant(0, 20);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b1000;
    rem[0] = 0; rem[3] = 1;
    mdl_busy = 4; mdl_data = 16'h9ABC;
    #1;
    chk("mrst_grant", {28'd0, bus.grant}, 32'd0);
    chk("mrst_done", {28'd0, bus.done}, 32'd0);
    chk("mrst_m_start", {31'd0, bus.m_start}, 32'd0);
    chk("mrst_m_addr", {25'd0, bus.m_addr}, 32'd0);
    chk("mrst_m_data", {16'd0, bus.m_data}, 32'd0);
    chk("mrst_m_rw", {31'd0, bus.m_rw}, 32'd0);
    chk("mrst_m_two", {31'd0, bus.m_two_bytes}, 32'd0);
    chk("mrst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("mrst_rsp_ack", {31'd0, bus.rsp_ack}, 32'd0);
    chk("mrst_rsp_to", {31'd0, bus.rsp_timeout}, 32'd0);
    exp_g.delete();
    exp_d.delete();
    push_g(3);
    push_d(3, 16'h9ABC, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("grant_after_reset", {28'd0, bus.grant}, 32'h8);
    wait_drain("after_reset", 100);

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int n;
      mdl_hang = 1'b1;
      mdl_busy = 3; mdl_data = 16'h4242;
      push_g(2);
      push_d(2, 16'h9ABC, 1'b0, 1'b1);
      rem[2] = 2;
      bus.req = 4'b0100;
      wait_grant(2, 20);
      n = 0;
      while (bus.done == 4'd0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", n, 32'd101);
      repeat (5) @(negedge clk);
      chk("no_grant_while_busy", {28'd0, bus.grant}, 32'd0);
      push_g(2);
      push_d(2, 16'h4242, 1'b1, 1'b0);
      mdl_hang = 1'b0;
      wait_drain("timeout", 300);
    end
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the single `i2c` master between four requesters, for example the sensor poller plus configuration and debug writers. Arbitration is round-robin. The arbiter latches the winner's transaction fields, pulses the master's `start`, and tracks the master's `ready` through busy and back to idle. It returns `read_data` and acknowledge status to the winner with a one-cycle done pulse. It sits between the requesting controllers and the `i2c` instance, which it drives exclusively.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 20'd1000000: watchdog limit in clk cycles per transaction (used only with `I2C_ARB_TIMEOUT_EN`).

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req`  input  4  per-requester request level; held until that requester's `done`.
- `req_addr`  input  28  7-bit slave address per requester; requester i uses bits [7i+6:7i].
- `req_data`  input  64  16-bit write data per requester, packed [16i+15:16i].
- `req_rw`  input  4  per-requester direction: 0 = write, 1 = read.
- `req_two_bytes`  input  4  per-requester byte count: 1 = two bytes, 0 = one byte.
- `grant`  output  4  one-hot; high for the granted requester for the whole transaction.
- `done`  output  4  one-hot, one-cycle pulse at the end of the transaction.
- `rsp_data`  output  16  `read_data` captured at completion; valid while `done` is high and held until the next completion.
- `rsp_ack`  output  1  master's `got_acknowledge` captured at completion.
- `rsp_timeout`  output  1  1 = the transaction was aborted by the watchdog.
- `m_start`, `m_addr[6:0]`, `m_data[15:0]`, `m_rw`, `m_two_bytes`  outputs  drive the `i2c` master inputs.
- `m_ready`, `m_read_data[15:0]`, `m_ack`  inputs  from the `i2c` master.

## Operation
State machine, encoded in a 3-bit register:
- **IDLE**: if `m_ready`=1 and `req`≠0, select a winner round-robin. The search starts at `last+1` mod 4, where `last` is the previously granted index. Latch the winner's address, data, rw and byte-count fields into the `m_*` registers. Set `grant[w]` and `m_start`=1. Go to ISSUE.
- **ISSUE**: `m_start`=0. Go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `m_ready`=0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `m_ready`=1. On that cycle capture `m_read_data`→`rsp_data` and `m_ack`→`rsp_ack`, and set `rsp_timeout`=0. Pulse `done[w]`, clear `grant`, set `last`=w, and go to IDLE.

Boundary and ordering rules:
- The `m_*` fields stay stable from ISSUE until the next grant. A requester changing its inputs mid-transaction has no effect.
- If `req[w]` drops mid-transaction, the transaction still completes and `done[w]` still pulses.
- When several requesters assert `req` in the same cycle, round-robin order decides.
- A requester holding `req` after its `done` is re-eligible. It wins again only if no other requester is pending.
- If `m_ready`=0 in IDLE, no grant is issued. Requests wait.
- Reset, including mid-transaction, forces:
  - outputs: `grant`=0, `done`=0, `m_start`=0, `m_addr`=0, `m_data`=0, `m_rw`=0, `m_two_bytes`=0, `rsp_data`=0, `rsp_ack`=0, `rsp_timeout`=0;
  - internal: state IDLE, `last`=3 (so requester 0 wins first).

## Timing
- Request sampled in IDLE at cycle N: `grant` and `m_start` go high at N+1. `m_start` is exactly one cycle wide.
- WAIT_BUSY is entered at N+2. A master that drops `ready` a cycle late is tolerated.
- `m_ready` rising observed in WAIT_DONE at cycle M:
  - `done`, `rsp_*` updated at M+1;
  - `grant` low at M+1;
  - next grant no earlier than M+2.
- Arbitration overhead is 2 cycles (grant and start) plus 1 cycle (done) around each master transaction.

## Configuration
`I2C_ARB_TIMEOUT_EN`:
- **Defined**: a 20-bit counter clears on grant and increments each cycle in WAIT_BUSY and WAIT_DONE. When it reaches `TIMEOUT_CYCLES`:
  - the arbiter goes to IDLE;
  - it pulses `done[w]` with `rsp_timeout`=1 and `rsp_ack`=0;
  - `rsp_data` keeps its prior value;
  - `last` updates as for a normal completion.

  IDLE then waits for `m_ready`=1 before granting again.
- **Not defined**: no counter. WAIT_BUSY and WAIT_DONE wait indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- **Single request**: reset; `req`=4'b0001, addr 7'h48, rw=1, two_bytes=1; master model goes busy for 50 cycles and returns data 16'h1A80 with ack=1.
  - Expect `m_start` one cycle at N+1 with `m_addr`=7'h48.
  - Expect `done`=4'b0001 with `rsp_data`=16'h1A80 and `rsp_ack`=1.
- **All four requesting**: `req`=4'b1111 held.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly one `m_start` per grant.
- **NACK**: master returns ack=0.
  - Expect `rsp_ack`=0 and `rsp_timeout`=0, with `done` still pulsed.
- **Request drop**: `req[2]` drops during WAIT_DONE.
  - Expect `done[2]` to pulse anyway.
  - Expect the next grant to follow round-robin from 2.
- **Reset mid-transaction**: assert `rst` in WAIT_DONE.
  - Expect all outputs 0 immediately.
  - After release with `req`=4'b1000 and `m_ready`=1, expect `grant`=4'b1000.
- **Timeout** (`I2C_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100): master holds `ready`=0.
  - Expect `done` 101 cycles after grant, with `rsp_timeout`=1.
  - Expect no new grant until `m_ready`=1.
